// File: rtl/tick_counter.sv
// tick_counter: divide-by-DIV prescaler driving an up/down counter
// with load, wrap/saturate and terminal-count pulses.
module tick_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 12000000,
    parameter int unsigned MAX   = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] data,
    output logic             tick,
    output logic             tc
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PTOP = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    logic [PW-1:0]    r_pres;
    logic [WIDTH-1:0] r_data;
    logic             r_tick;
    logic             r_tc;

    logic             w_step;
    logic             w_bound;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_clamp;

    assign w_step  = en && !load && (r_pres == PTOP);
    assign w_bound = dir ? (r_data == MAXV) : (r_data == '0);
    assign w_clamp = (load_val > MAXV) ? MAXV : load_val;

    // Next count on a step: move one toward dir, or wrap/hold at a bound
    always_comb begin
        w_next = r_data;
        if (dir) begin
            if (w_bound) w_next = sat ? MAXV : '0;
            else         w_next = r_data + WIDTH'(1);
        end else begin
            if (w_bound) w_next = sat ? '0 : MAXV;
            else         w_next = r_data - WIDTH'(1);
        end
    end

    // Prescaler, count register and one-cycle step/bound pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pres <= '0;
            r_data <= '0;
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end else if (load) begin
            r_pres <= '0;
            r_data <= w_clamp;
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end else if (en) begin
            r_pres <= w_step ? '0 : r_pres + PW'(1);
            if (w_step) r_data <= w_next;
            r_tick <= w_step;
            r_tc   <= w_step && w_bound;
        end else begin
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end
    end

    assign data = r_data;
    assign tick = r_tick;
    assign tc   = r_tc;

endmodule

// File: tb/tb_tick_counter.sv
// tb_tick_counter: randomized scoreboard bench for tick_counter
// using two instances (DIV=4/MAX=9 and DIV=1/MAX=7).
module tb_tick_counter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic       a_en = 0, a_dir = 0, a_sat = 0, a_load = 0;
    logic [3:0] a_lv = '0;
    logic [3:0] a_data;
    logic       a_tick, a_tc;

    logic       b_en = 0, b_dir = 0, b_sat = 0, b_load = 0;
    logic [2:0] b_lv = '0;
    logic [2:0] b_data;
    logic       b_tick, b_tc;

    tick_counter #(.WIDTH(4), .DIV(4), .MAX(9)) u_a (
        .clk(clk), .rstn(rstn), .en(a_en), .dir(a_dir), .sat(a_sat),
        .load(a_load), .load_val(a_lv), .data(a_data), .tick(a_tick),
        .tc(a_tc)
    );

    tick_counter #(.WIDTH(3), .DIV(1), .MAX(7)) u_b (
        .clk(clk), .rstn(rstn), .en(b_en), .dir(b_dir), .sat(b_sat),
        .load(b_load), .load_val(b_lv), .data(b_data), .tick(b_tick),
        .tc(b_tc)
    );

    typedef struct {
        int data;
        int tick;
        int tc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int n_chk = 0;
    int n_fail = 0;

    // model state: count value and number of enabled cycles since phase origin
    int m_data[2];
    int m_cnt[2];

    function automatic int pdiv(int id);
        return (id == 0) ? 4 : 1;
    endfunction

    function automatic int pmax(int id);
        return (id == 0) ? 9 : 7;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic model_step(input int id, input bit en, input bit dir,
                              input bit sat, input bit load, input int lv,
                              output exp_t e);
        int mx;
        bit bnd;
        mx = pmax(id);
        e.tick = 0;
        e.tc   = 0;
        if (load) begin
            m_data[id] = (lv > mx) ? mx : lv;
            m_cnt[id]  = 0;
        end else if (en) begin
            m_cnt[id]++;
            if (m_cnt[id] % pdiv(id) == 0) begin
                bnd = dir ? (m_data[id] == mx) : (m_data[id] == 0);
                if (dir) begin
                    if (!bnd)     m_data[id] = m_data[id] + 1;
                    else if (!sat) m_data[id] = 0;
                end else begin
                    if (!bnd)     m_data[id] = m_data[id] - 1;
                    else if (!sat) m_data[id] = mx;
                end
                e.tick = 1;
                e.tc   = bnd ? 1 : 0;
            end
        end
        e.data = m_data[id];
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // one clock of stimulus on DUT id; the other DUT is idled
    task automatic cyc(input int id, input bit en, input bit dir,
                       input bit sat, input bit load, input int lv);
        exp_t ea, eb;
        @(posedge clk);
        #2;
        rstn = 1'b1;
        if (id == 0) begin
            a_en = en; a_dir = dir; a_sat = sat; a_load = load;
            a_lv = 4'(lv);
            b_en = 0; b_load = 0;
            model_step(0, en, dir, sat, load, lv, ea);
            model_step(1, 0, 0, 0, 0, 0, eb);
        end else begin
            b_en = en; b_dir = dir; b_sat = sat; b_load = load;
            b_lv = 3'(lv);
            a_en = 0; a_load = 0;
            model_step(0, 0, 0, 0, 0, 0, ea);
            model_step(1, en, dir, sat, load, lv, eb);
        end
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    // asynchronous reset asserted between edges, held for n cycles
    task automatic rst_cycles(input int n);
        exp_t z;
        z = '{0, 0, 0};
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            rstn = 1'b0;
            model_reset();
            qa.push_back(z);
            qb.push_back(z);
            if (i == 0) begin
                #1;
                chk("async_rst_a_data", int'(a_data), 0);
                chk("async_rst_a_tick", int'(a_tick), 0);
                chk("async_rst_a_tc", int'(a_tc), 0);
                chk("async_rst_b_data", int'(b_data), 0);
            end
        end
    endtask

    // monitor: compare every presented output against the scoreboard
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            n_chk++;
            if (a_data != 4'(e.data) || a_tick != e.tick[0] ||
                a_tc != e.tc[0]) begin
                n_fail++;
                $display("FAIL dut_a @%0t: got data=%0d tick=%0d tc=%0d expected data=%0d tick=%0d tc=%0d",
                         $time, a_data, a_tick, a_tc, e.data, e.tick, e.tc);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            n_chk++;
            if (b_data != 3'(e.data) || b_tick != e.tick[0] ||
                b_tc != e.tc[0]) begin
                n_fail++;
                $display("FAIL dut_b @%0t: got data=%0d tick=%0d tc=%0d expected data=%0d tick=%0d tc=%0d",
                         $time, b_data, b_tick, b_tc, e.data, e.tick, e.tc);
            end
        end
    end

    initial begin
        model_reset();
        rstn = 1'b0;
        #23;
        chk("reset_a_data", int'(a_data), 0);
        chk("reset_a_tick", int'(a_tick), 0);
        chk("reset_a_tc", int'(a_tc), 0);
        chk("reset_b_data", int'(b_data), 0);

        // count up with wrap through 9 -> 0
        for (int i = 0; i < 44; i++) cyc(0, 1, 1, 0, 0, 0);
        // count down with wrap 0 -> 9
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0, 0);
        // saturate at 0 going down
        cyc(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 1, 0, 0);
        // load above MAX clamps
        cyc(0, 1, 1, 0, 1, 13);
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0, 0);
        // load coinciding with prescaler terminal
        for (int i = 0; i < 8 && (m_cnt[0] % 4) != 3; i++)
            cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 5);
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0, 0);
        // enable low for 5 cycles mid-period
        for (int i = 0; i < 8 && (m_cnt[0] % 4) != 2; i++)
            cyc(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0, 0);

        // DUT B: DIV=1 saturating up
        for (int i = 0; i < 12; i++) cyc(1, 1, 1, 1, 0, 0);
        // DUT B: randomized
        for (int i = 0; i < 150; i++)
            cyc(1, ($urandom_range(3) != 0), $urandom_range(1),
                $urandom_range(1), ($urandom_range(15) == 0),
                $urandom_range(7));

        // DUT A: randomized
        for (int i = 0; i < 300; i++)
            cyc(0, ($urandom_range(3) != 0), $urandom_range(1),
                $urandom_range(1), ($urandom_range(19) == 0),
                $urandom_range(15));

        // bring A to 6, then async reset between edges
        cyc(0, 1, 1, 0, 1, 5);
        for (int i = 0; i < 10 && m_data[0] != 6; i++)
            cyc(0, 1, 1, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("pre_reset_a_data", int'(a_data), 6);
        qa.delete();
        qb.delete();
        rst_cycles(3);
        for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, 0);

        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drained", qa.size() + qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
